sdp_core_chn_in_rsci_skid: RTL and testbench

Parametrised input-channel interface for SDP core pipelines, the successor of the single-register in-wire-wait channel wrappers. It accepts a valid/ready stream from an upstream SDP stage into a DEPTH-entry skid FIFO and presents it to the core under the core stall protocol (oswt / core_wen / core_wten / wen_comp). Its upstream ready comes from a flop, so there is no combinational path from the core stall logic back to the producer. An optional same-cycle bypass provides zero-latency forwarding when the FIFO is empty.

---
 rtl/sdp_core_chn_pkg.sv | 18 +
 rtl/sdp_core_chn_in_rsci_skid_mem.sv | 28 ++
 rtl/sdp_core_chn_in_rsci_skid.sv | 106 ++++++++++
 tb/tb_sdp_core_chn_in_rsci_skid.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_core_chn_pkg.sv
// Shared definitions for the SDP core channel wrappers: default payload width,
// the core stall-protocol bundle and the occupancy-counter width helper.
package sdp_core_chn_pkg;

    localparam int unsigned SDP_CHN_DEF_WIDTH = 740;

    typedef struct packed {
        logic oswt;
        logic wen;
        logic wten;
    } sdp_chn_stall_t;

    // A DEPTH-entry FIFO needs to represent 0..DEPTH inclusive.
    function automatic int unsigned sdp_chn_occ_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sdp_core_chn_in_rsci_skid_mem.sv
// Skid FIFO storage: DEPTH x WIDTH register array, one write port, async read.
module sdp_core_chn_in_rsci_skid_mem
    import sdp_core_chn_pkg::*;
#(
    parameter int unsigned WIDTH = SDP_CHN_DEF_WIDTH,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Payload storage is deliberately left without reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sdp_core_chn_in_rsci_skid.sv
// Input channel for SDP core pipelines: valid/ready upstream into a skid FIFO,
// presented to the core under the oswt/core_wen/core_wten stall protocol.
module sdp_core_chn_in_rsci_skid
    import sdp_core_chn_pkg::*;
#(
    parameter int unsigned WIDTH  = SDP_CHN_DEF_WIDTH,
    parameter int unsigned DEPTH  = 2,
    parameter bit          BYPASS = 1'b0,
    parameter int unsigned CW     = sdp_chn_occ_w(DEPTH)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic [WIDTH-1:0] chn_in_rsc_z,
    input  logic             chn_in_rsc_vz,
    output logic             chn_in_rsc_lz,
    input  logic             chn_in_rsci_oswt,
    input  logic             core_wen,
    input  logic             core_wten,
    output logic             chn_in_rsci_bawt,
    output logic             chn_in_rsci_wen_comp,
    output logic [WIDTH-1:0] chn_in_rsci_d_mxwt,
    output logic [CW-1:0]    chn_in_rsci_cnt
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lz_q, lz_d;
    logic [WIDTH-1:0] held_q, held_d;
    logic [WIDTH-1:0] head;
    sdp_chn_stall_t   stall;
    logic             empty, push, pop, byp, bawt, wr_en, rd_en;
    logic [WIDTH-1:0] d_mxwt;

    always_comb begin
        stall.oswt = chn_in_rsci_oswt;
        stall.wen  = core_wen;
        stall.wten = core_wten;
    end

    always_comb begin
        empty = (cnt_q == '0);
        push  = chn_in_rsc_vz & lz_q;
        bawt  = ~empty | (BYPASS & chn_in_rsc_vz & lz_q);
        // wten is redundant with wen under the protocol; gating on it keeps a
        // stalled core from consuming even if wen glitches high.
        pop   = stall.oswt & stall.wen & ~stall.wten & bawt;
        byp   = BYPASS & empty & push & stall.oswt & stall.wen & ~stall.wten;
        wr_en = push & ~byp;
        rd_en = pop & ~byp;

        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        cnt_d    = cnt_q + CW'(wr_en) - CW'(rd_en);
        // Ready falls in the same cycle the last slot fills.
        lz_d     = (cnt_d != FULL_CNT);

        if (!empty) begin
            d_mxwt = head;
        end else if (BYPASS) begin
            d_mxwt = chn_in_rsc_z;
        end else begin
            d_mxwt = held_q;
        end
        held_d = pop ? d_mxwt : held_q;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            lz_q     <= 1'b0;
            held_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            lz_q     <= lz_d;
            held_q   <= held_d;
        end
    end

    sdp_core_chn_in_rsci_skid_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (nvdla_core_clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (chn_in_rsc_z),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    assign chn_in_rsc_lz        = lz_q;
    assign chn_in_rsci_bawt     = bawt;
    assign chn_in_rsci_wen_comp = ~stall.oswt | bawt;
    assign chn_in_rsci_d_mxwt   = d_mxwt;
    assign chn_in_rsci_cnt      = cnt_q;

endmodule

// File: tb/tb_sdp_core_chn_in_rsci_skid.sv
// Bench for sdp_core_chn_in_rsci_skid: DEPTH=2 table, BYPASS=1 sequence,
// DEPTH=4 scoreboarded stream, and asynchronous reset in mid-transfer.
module tb_sdp_core_chn_in_rsci_skid;

    logic clk;
    logic rstn;

    // a_: DEPTH=2, BYPASS=0
    logic [15:0] a_z, a_d;
    logic        a_vz, a_lz, a_oswt, a_wen, a_wten, a_bawt, a_wc;
    logic [1:0]  a_cnt;
    // b_: DEPTH=2, BYPASS=1
    logic [15:0] b_z, b_d;
    logic        b_vz, b_lz, b_oswt, b_wen, b_wten, b_bawt, b_wc;
    logic [1:0]  b_cnt;
    // c_: DEPTH=4, BYPASS=0
    logic [15:0] c_z, c_d;
    logic        c_vz, c_lz, c_oswt, c_wen, c_wten, c_bawt, c_wc;
    logic [2:0]  c_cnt;

    int tests = 0;
    int fails = 0;

    sdp_core_chn_in_rsci_skid #(.WIDTH(16), .DEPTH(2), .BYPASS(1'b0)) u_a (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .chn_in_rsc_z(a_z), .chn_in_rsc_vz(a_vz), .chn_in_rsc_lz(a_lz),
        .chn_in_rsci_oswt(a_oswt), .core_wen(a_wen), .core_wten(a_wten),
        .chn_in_rsci_bawt(a_bawt), .chn_in_rsci_wen_comp(a_wc),
        .chn_in_rsci_d_mxwt(a_d), .chn_in_rsci_cnt(a_cnt));

    sdp_core_chn_in_rsci_skid #(.WIDTH(16), .DEPTH(2), .BYPASS(1'b1)) u_b (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .chn_in_rsc_z(b_z), .chn_in_rsc_vz(b_vz), .chn_in_rsc_lz(b_lz),
        .chn_in_rsci_oswt(b_oswt), .core_wen(b_wen), .core_wten(b_wten),
        .chn_in_rsci_bawt(b_bawt), .chn_in_rsci_wen_comp(b_wc),
        .chn_in_rsci_d_mxwt(b_d), .chn_in_rsci_cnt(b_cnt));

    sdp_core_chn_in_rsci_skid #(.WIDTH(16), .DEPTH(4), .BYPASS(1'b0)) u_c (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .chn_in_rsc_z(c_z), .chn_in_rsc_vz(c_vz), .chn_in_rsc_lz(c_lz),
        .chn_in_rsci_oswt(c_oswt), .core_wen(c_wen), .core_wten(c_wten),
        .chn_in_rsci_bawt(c_bawt), .chn_in_rsci_wen_comp(c_wc),
        .chn_in_rsci_d_mxwt(c_d), .chn_in_rsci_cnt(c_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vz;
        logic [15:0] z;
        logic        oswt, wen, wten;
        logic        e_lz, e_bawt, e_wc;
        logic [1:0]  e_cnt;
        logic [15:0] e_d;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic vz, input logic [15:0] z, input logic oswt, input logic wen,
                       input logic wten, input logic lz, input logic bawt, input logic wc,
                       input logic [1:0] cnt, input logic [15:0] d);
        vec_t v;
        v.vz = vz; v.z = z; v.oswt = oswt; v.wen = wen; v.wten = wten;
        v.e_lz = lz; v.e_bawt = bawt; v.e_wc = wc; v.e_cnt = cnt; v.e_d = d;
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, got, exp);
        end
    endtask

    // Packs {lz,bawt,wen_comp,cnt,d} for the DEPTH=2 instances.
    function automatic logic [63:0] pk(input logic lz, input logic bawt, input logic wc,
                                       input logic [1:0] cnt, input logic [15:0] d);
        return {43'd0, lz, bawt, wc, cnt, d};
    endfunction

    task automatic drive_b(input logic vz, input logic [15:0] z, input logic oswt, input logic wen);
        @(negedge clk);
        b_vz = vz; b_z = z; b_oswt = oswt; b_wen = wen; b_wten = 1'b0;
        #1;
    endtask

    initial begin
        logic [15:0] sbq[$];
        logic [15:0] exp_v;
        int sent, recv;
        logic [2:0] max_cnt;

        //           vz z      os wen wt | lz bw wc cnt d
        add(1, 16'h5A, 0, 0, 0,  1, 0, 1, 0, 16'h0000);
        add(0, 16'h00, 0, 0, 0,  1, 1, 1, 1, 16'h005A);
        add(0, 16'h00, 1, 1, 0,  1, 1, 1, 1, 16'h005A);
        add(1, 16'h01, 0, 0, 0,  1, 0, 1, 0, 16'h005A);
        add(1, 16'h02, 0, 0, 0,  1, 1, 1, 1, 16'h0001);
        add(1, 16'h03, 0, 0, 0,  0, 1, 1, 2, 16'h0001);
        add(1, 16'h03, 0, 0, 0,  0, 1, 1, 2, 16'h0001);
        add(1, 16'h03, 1, 1, 0,  0, 1, 1, 2, 16'h0001);
        add(1, 16'h03, 0, 0, 0,  1, 1, 1, 1, 16'h0002);
        add(0, 16'h00, 1, 1, 0,  0, 1, 1, 2, 16'h0002);
        add(1, 16'h07, 1, 1, 0,  1, 1, 1, 1, 16'h0003);
        add(0, 16'h00, 0, 0, 0,  1, 1, 1, 1, 16'h0007);
        add(0, 16'h00, 1, 1, 0,  1, 1, 1, 1, 16'h0007);
        add(0, 16'h00, 1, 0, 0,  1, 0, 0, 0, 16'h0007);
        add(0, 16'h00, 1, 1, 0,  1, 0, 0, 0, 16'h0007);
        add(0, 16'h00, 0, 0, 0,  1, 0, 1, 0, 16'h0007);
        add(1, 16'hAB, 0, 0, 0,  1, 0, 1, 0, 16'h0007);
        add(1, 16'hCD, 1, 0, 1,  1, 1, 1, 1, 16'h00AB);
        for (int k = 0; k < 4; k++) add(1, 16'hCD, 1, 0, 1,  0, 1, 1, 2, 16'h00AB);
        add(0, 16'h00, 1, 1, 0,  0, 1, 1, 2, 16'h00AB);
        add(0, 16'h00, 1, 1, 0,  1, 1, 1, 1, 16'h00CD);
        add(0, 16'h00, 0, 0, 0,  1, 0, 1, 0, 16'h00CD);

        rstn = 1'b0;
        a_vz = 1'b1; a_z = 16'h5A; a_oswt = 1'b0; a_wen = 1'b0; a_wten = 1'b0;
        b_vz = 1'b1; b_z = 16'h00; b_oswt = 1'b0; b_wen = 1'b0; b_wten = 1'b0;
        c_vz = 1'b1; c_z = 16'h00; c_oswt = 1'b0; c_wen = 1'b0; c_wten = 1'b0;

        // Reset state with upstream valid asserted.
        repeat (2) @(negedge clk);
        #1;
        check("reset_a", pk(a_lz, a_bawt, a_wc, a_cnt, a_d), pk(0, 0, 1, 0, 16'h0000));
        check("reset_b", {61'd0, b_lz, b_bawt, b_cnt == 2'd0}, {61'd0, 3'b001});
        check("reset_c", {60'd0, c_lz, c_bawt, c_cnt}, 64'd0);

        @(negedge clk);
        rstn = 1'b1; b_vz = 1'b0; c_vz = 1'b0;
        #1;
        check("lz_before_edge", {63'd0, a_lz}, 64'd0);

        // DEPTH=2 table: inputs set, outputs compared before the next edge.
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            a_vz = vq[i].vz; a_z = vq[i].z; a_oswt = vq[i].oswt;
            a_wen = vq[i].wen; a_wten = vq[i].wten;
            #1;
            check($sformatf("d2_row%0d", i), pk(a_lz, a_bawt, a_wc, a_cnt, a_d),
                  pk(vq[i].e_lz, vq[i].e_bawt, vq[i].e_wc, vq[i].e_cnt, vq[i].e_d));
        end

        // BYPASS=1: same-cycle forwarding and the non-forwarded paths.
        drive_b(1, 16'h33, 1, 1);
        check("byp_fwd", pk(b_lz, b_bawt, b_wc, b_cnt, b_d), pk(1, 1, 1, 0, 16'h0033));
        drive_b(0, 16'h44, 0, 0);
        check("byp_after", pk(b_lz, b_bawt, b_wc, b_cnt, b_d), pk(1, 0, 1, 0, 16'h0044));
        drive_b(0, 16'h44, 1, 1);
        check("byp_starve", pk(b_lz, b_bawt, b_wc, b_cnt, b_d), pk(1, 0, 0, 0, 16'h0044));
        drive_b(1, 16'h55, 1, 0);
        check("byp_nowen", pk(b_lz, b_bawt, b_wc, b_cnt, b_d), pk(1, 1, 1, 0, 16'h0055));
        drive_b(1, 16'h66, 1, 1);
        check("byp_pushpop", pk(b_lz, b_bawt, b_wc, b_cnt, b_d), pk(1, 1, 1, 1, 16'h0055));
        drive_b(0, 16'h00, 0, 0);
        check("byp_head", pk(b_lz, b_bawt, b_wc, b_cnt, b_d), pk(1, 1, 1, 1, 16'h0066));
        drive_b(0, 16'h00, 1, 1);
        drive_b(0, 16'h77, 0, 0);
        check("byp_drained", pk(b_lz, b_bawt, b_wc, b_cnt, b_d), pk(1, 0, 1, 0, 16'h0077));

        // DEPTH=4 stream: scoreboard of pushed beats against popped beats.
        sent = 0; recv = 0; max_cnt = '0;
        for (int cyc = 0; cyc < 500 && recv < 10; cyc++) begin
            @(negedge clk);
            c_vz   = (sent < 10) ? ($urandom_range(0, 3) != 0) : 1'b0;
            c_z    = 16'h0100 + 16'(sent);
            c_oswt = 1'($urandom_range(0, 1));
            c_wen  = ($urandom_range(0, 2) == 0);
            c_wten = 1'b0;
            #1;
            if (c_cnt > max_cnt) max_cnt = c_cnt;
            check("wrap_state", {60'd0, c_bawt, c_cnt}, {60'd0, sbq.size() != 0, 3'(sbq.size())});
            if (c_oswt && c_wen && c_bawt) begin
                if (sbq.size() == 0) begin
                    check("wrap_dup", 64'd1, 64'd0);
                end else begin
                    exp_v = sbq.pop_front();
                    check("wrap_data", {48'd0, c_d}, {48'd0, exp_v});
                    recv++;
                end
            end
            if (c_vz && c_lz) begin
                sbq.push_back(c_z);
                sent++;
            end
        end
        @(negedge clk);
        c_vz = 1'b0; c_oswt = 1'b0; c_wen = 1'b0;
        check("wrap_count", {32'd0, 32'(recv)}, 64'd10);
        check("wrap_maxcnt", {63'd0, max_cnt <= 3'd4}, 64'd1);

        // Asynchronous reset while the DEPTH=2 FIFO holds data.
        @(negedge clk);
        a_vz = 1'b1; a_z = 16'h11; a_oswt = 1'b0; a_wen = 1'b0;
        @(negedge clk);
        a_z = 16'h22;
        @(negedge clk);
        a_vz = 1'b0;
        #1;
        check("pre_reset_full", {62'd0, a_cnt}, 64'd2);
        #1 rstn = 1'b0;
        #1;
        check("async_reset", pk(a_lz, a_bawt, a_wc, a_cnt, a_d), pk(0, 0, 1, 0, 16'h0000));
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        a_vz = 1'b1; a_z = 16'h99;
        #1;
        check("after_reset", pk(a_lz, a_bawt, a_wc, a_cnt, a_d), pk(1, 0, 1, 0, 16'h0000));
        @(negedge clk);
        a_vz = 1'b0;
        #1;
        check("after_reset_push", pk(a_lz, a_bawt, a_wc, a_cnt, a_d), pk(1, 1, 1, 1, 16'h0099));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
